pc_update_unit: RTL
===================

// Module: pc_update_unit
// PURPOSE
//   Program-counter register stage that consumes the selected next-PC value from the PC source mux.
//   Decides each cycle whether PC loads: unconditional write, or conditional branch on ALU flags.
//   Owns the EPC register and the exception-entry sequence: capture return PC, then load the handler vector.
//   Output pc_out drives instruction fetch (memory address mux); epc_out feeds back into the PC source mux.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC value after reset
//   PC_INC       4              offset subtracted from pc_out when EPC is captured (PC already advanced)
//   VECTOR_WIDTH 8              low bits of pc_in used as handler address during vector load
//   CHECK_ALIGN  1              1: refuse to load word-misaligned PC values; 0: no check
// PORTS
//   clk            in   1   system clock, all state on rising edge
//   reset          in   1   synchronous, active-high
//   pc_in          in   32  next-PC candidate from PC source mux
//   pc_write       in   1   unconditional PC load request
//   pc_write_cond  in   1   conditional (branch) PC load request
//   branch_op      in   2   00 beq(zero) 01 bne(!zero) 10 ble(zero|lt) 11 bgt(gt)
//   alu_zero       in   1   ALU zero flag
//   alu_lt         in   1   ALU less-than flag
//   alu_gt         in   1   ALU greater-than flag
//   exc_req        in   1   exception entry request from control unit (1-cycle pulse)
//   vector_load    in   1   handler vector valid on pc_in[VECTOR_WIDTH-1:0]
//   pc_out         out  32  current PC
//   epc_out        out  32  saved exception return PC
//   exc_busy       out  1   high while in EXC_WAIT
//   pc_loaded      out  1   1-cycle pulse: PC was loaded in the previous cycle
//   misaligned     out  1   1-cycle pulse: a load was refused due to pc_in[1:0]!=0
//   exc_overrun    out  1   sticky: exc_req arrived while exc_busy; cleared only by reset
// BEHAVIOUR
//   Reset (sync, priority over everything): pc_out=RESET_PC, epc_out=0, state=RUN, all flags 0.
//   take = pc_write | (pc_write_cond & cond(branch_op,flags)); cond evaluated combinationally same cycle.
//   State RUN:
//     exc_req=1 -> epc_out<=pc_out-PC_INC (mod 2^32), pc held, state->EXC_WAIT; overrides take.
//     else take & (aligned | !CHECK_ALIGN) -> pc_out<=pc_in next edge, pc_loaded=1 following cycle.
//     else take & misaligned -> pc held, misaligned=1 following cycle.
//     vector_load in RUN is ignored.
//   State EXC_WAIT (exc_busy=1):
//     pc_write/pc_write_cond ignored; epc_out frozen.
//     vector_load=1 -> pc_out<={zeros, pc_in[VECTOR_WIDTH-1:0]}, pc_loaded=1, state->RUN; no align check.
//     exc_req=1 -> exc_overrun<=1, EPC not overwritten; if simultaneous with vector_load, vector still taken.
//   Latency: every load visible on pc_out one cycle after the request edge; no bypass pc_in->pc_out.
//   pc_loaded/misaligned are registered pulses, high exactly one cycle per event.
//   EPC subtraction wraps: pc_out=0, PC_INC=4 -> epc_out=32'hFFFF_FFFC.
//   Reset during EXC_WAIT aborts the sequence: state RUN, epc_out=0.
// TESTING
//   reset; pc_in=32'h40, pc_write=1 one cycle -> pc_out=32'h40 next cycle, pc_loaded pulse once.
//   pc_write_cond=1, branch_op=00, alu_zero=0 -> pc_out unchanged; repeat with alu_zero=1 -> loads pc_in.
//   branch_op 01/10/11 swept against all zero/lt/gt combos -> load only when cond true.
//   pc_out=32'h100, exc_req -> epc_out=32'hFC, exc_busy=1; pc_write ignored; vector_load pc_in=32'hABCD_1234 -> pc_out=32'h34.
//   exc_req in EXC_WAIT -> exc_overrun=1, epc_out unchanged; reset -> exc_overrun=0, pc_out=RESET_PC.
//   pc_in=32'h42, pc_write=1 -> pc_out held, misaligned pulse; reset asserted with pc_write -> reset wins.

Source files
------------

// File: rtl/pc_update_unit.sv
// Program-counter register stage: unconditional/conditional PC loads, alignment
// screening, and the two-step exception entry (capture EPC, then load handler vector).
module pc_update_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned PC_INC       = 4,
  parameter int unsigned VECTOR_WIDTH = 8,
  parameter bit          CHECK_ALIGN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic        vector_load,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic        exc_busy,
  output logic        pc_loaded,
  output logic        misaligned,
  output logic        exc_overrun
);

  typedef enum logic {ST_RUN, ST_EXC_WAIT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_loaded;
  logic        r_misal;
  logic        r_overrun;

  logic        w_cond;
  logic        w_take;
  logic        w_load_ok;

  function automatic logic branch_cond(input logic [1:0] op, input logic z,
                                       input logic lt, input logic gt);
    case (op)
      2'b00:   branch_cond = z;
      2'b01:   branch_cond = ~z;
      2'b10:   branch_cond = z | lt;
      default: branch_cond = gt;
    endcase
  endfunction

  always_comb begin
    w_cond    = branch_cond(branch_op, alu_zero, alu_lt, alu_gt);
    w_take    = pc_write | (pc_write_cond & w_cond);
    w_load_ok = (pc_in[1:0] == 2'b00) || !CHECK_ALIGN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_epc     <= 32'h0;
      r_loaded  <= 1'b0;
      r_misal   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_loaded <= 1'b0;
      r_misal  <= 1'b0;
      case (r_state)
        ST_RUN: begin
          // Exception entry outranks any PC load requested in the same cycle.
          if (exc_req) begin
            r_epc   <= r_pc - 32'(PC_INC);
            r_state <= ST_EXC_WAIT;
          end else if (w_take) begin
            if (w_load_ok) begin
              r_pc     <= pc_in;
              r_loaded <= 1'b1;
            end else begin
              r_misal  <= 1'b1;
            end
          end
        end
        ST_EXC_WAIT: begin
          if (exc_req) r_overrun <= 1'b1;
          if (vector_load) begin
            r_pc     <= 32'(pc_in[VECTOR_WIDTH-1:0]);
            r_loaded <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign pc_out      = r_pc;
  assign epc_out     = r_epc;
  assign exc_busy    = (r_state == ST_EXC_WAIT);
  assign pc_loaded   = r_loaded;
  assign misaligned  = r_misal;
  assign exc_overrun = r_overrun;

endmodule
